// File: rtl/butterfly_pipe.sv
// Pipelined, handshaked modular radix-2 butterfly (CT for NTT, GS for INTT), latency 3.
// Whole-pipe stall on output backpressure; one butterfly per clock when unstalled.
module butterfly_pipe #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MODULUS    = 17,
   parameter int unsigned TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [DATA_WIDTH-1:0] in_u,
   input  logic [DATA_WIDTH-1:0] in_v,
   input  logic [DATA_WIDTH-1:0] in_twiddle,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  busy
);

   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] MOD_D = DATA_WIDTH'(MODULUS);
   localparam logic [DATA_WIDTH:0]   MOD_S = (DATA_WIDTH + 1)'(MODULUS);
   localparam logic [PROD_WIDTH-1:0] MOD_P = PROD_WIDTH'(MODULUS);

   // Operands are already reduced, so one conditional subtract suffices.
   function automatic logic [DATA_WIDTH-1:0] add_mod(input logic [DATA_WIDTH-1:0] x,
                                                     input logic [DATA_WIDTH-1:0] y);
      logic [DATA_WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= MOD_S) s = s - MOD_S;
      return s[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sub_mod(input logic [DATA_WIDTH-1:0] x,
                                                     input logic [DATA_WIDTH-1:0] y);
      logic [DATA_WIDTH-1:0] d;
      if (x >= y) d = x - y;
      else        d = MOD_D - (y - x);
      return d;
   endfunction

   logic                  adv;
   logic [DATA_WIDTH-1:0] u_n, v_n, w_n, r;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_mode_q, s1_mode_d;
   logic [DATA_WIDTH-1:0] s1_pass_q, s1_pass_d;
   logic [DATA_WIDTH-1:0] s1_mul_q, s1_mul_d;
   logic [DATA_WIDTH-1:0] s1_w_q, s1_w_d;
   logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

   logic                  s2_valid_q, s2_valid_d;
   logic                  s2_mode_q, s2_mode_d;
   logic [DATA_WIDTH-1:0] s2_pass_q, s2_pass_d;
   logic [PROD_WIDTH-1:0] s2_prod_q, s2_prod_d;
   logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
   logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
   logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_tag   = out_tag_q;
   assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

   assign u_n = in_u % MOD_D;
   assign v_n = in_v % MOD_D;
   assign w_n = in_twiddle % MOD_D;
   assign r   = DATA_WIDTH'(s2_prod_q % MOD_P);

   // Next-state for all three stages; everything holds when the output is stalled.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_mode_d   = s1_mode_q;
      s1_pass_d   = s1_pass_q;
      s1_mul_d    = s1_mul_q;
      s1_w_d      = s1_w_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_mode_d   = s2_mode_q;
      s2_pass_d   = s2_pass_q;
      s2_prod_d   = s2_prod_q;
      s2_tag_d    = s2_tag_q;
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_tag_d   = out_tag_q;

      if (adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_mode_d = in_mode;
            s1_w_d    = w_n;
            s1_tag_d  = in_tag;
            if (in_mode) begin
               s1_pass_d = add_mod(u_n, v_n);
               s1_mul_d  = sub_mod(u_n, v_n);
            end else begin
               s1_pass_d = u_n;
               s1_mul_d  = v_n;
            end
         end

         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_mode_d = s1_mode_q;
            s2_pass_d = s1_pass_q;
            s2_prod_d = PROD_WIDTH'(s1_mul_q) * PROD_WIDTH'(s1_w_q);
            s2_tag_d  = s1_tag_q;
         end

         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            out_tag_d = s2_tag_q;
            if (s2_mode_q) begin
               out_a_d = s2_pass_q;
               out_b_d = r;
            end else begin
               out_a_d = add_mod(s2_pass_q, r);
               out_b_d = sub_mod(s2_pass_q, r);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_pass_q   <= '0;
         s1_mul_q    <= '0;
         s1_w_q      <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_mode_q   <= 1'b0;
         s2_pass_q   <= '0;
         s2_prod_q   <= '0;
         s2_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s1_pass_q   <= s1_pass_d;
         s1_mul_q    <= s1_mul_d;
         s1_w_q      <= s1_w_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_mode_q   <= s2_mode_d;
         s2_pass_q   <= s2_pass_d;
         s2_prod_q   <= s2_prod_d;
         s2_tag_q    <= s2_tag_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_tag_q   <= out_tag_d;
      end
   end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (MODULUS=17, DATA_WIDTH=16, TAG_WIDTH=4).
module tb_butterfly_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [15:0] in_u;
   logic [15:0] in_v;
   logic [15:0] in_twiddle;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic [3:0]  out_tag;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   butterfly_pipe #(.DATA_WIDTH(16), .MODULUS(17), .TAG_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_u(in_u), .in_v(in_v), .in_twiddle(in_twiddle), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_tag(out_tag), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   // Plain integer reference of the butterfly, {a, b}.
   function automatic logic [31:0] ref_ab(input logic mode, input int u, input int v, input int w);
      int un, vn, wn, t, a, b;
      un = u % 17; vn = v % 17; wn = w % 17;
      if (!mode) begin
         t = (vn * wn) % 17;
         a = (un + t) % 17;
         b = (un - t + 17) % 17;
      end else begin
         a = (un + vn) % 17;
         b = (((un - vn + 17) % 17) * wn) % 17;
      end
      return {16'(a), 16'(b)};
   endfunction

   // Sends one transaction into an idle pipe and returns the result and its latency.
   task automatic run_one(input logic mode, input logic [15:0] u, input logic [15:0] v,
                          input logic [15:0] w, input logic [3:0] tag,
                          output logic [15:0] a, output logic [15:0] b,
                          output logic [3:0] otag, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_mode = mode; in_u = u; in_v = v; in_twiddle = w; in_tag = tag;
      out_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 10);
      a = out_a; b = out_b; otag = out_tag;
   endtask

   task automatic test_reset();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid: out_valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      n_checks++;
      if (out_a !== 16'd0 || out_b !== 16'd0 || out_tag !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_data: a=%0d b=%0d tag=%0d expected 0 0 0", out_a, out_b, out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic check_one(input string name, input logic mode, input logic [15:0] u,
                            input logic [15:0] v, input logic [15:0] w, input logic [3:0] tag,
                            input logic [15:0] ea, input logic [15:0] eb);
      logic [15:0] a, b;
      logic [3:0]  t;
      int          lat;
      run_one(mode, u, v, w, tag, a, b, t, lat);
      n_checks++;
      if (lat !== 3) begin
         n_errors++;
         $display("FAIL %s latency: got %0d expected 3", name, lat);
      end
      n_checks++;
      if (a !== ea || b !== eb || t !== tag) begin
         n_errors++;
         $display("FAIL %s result: a=%0d b=%0d tag=%0d expected a=%0d b=%0d tag=%0d",
                  name, a, b, t, ea, eb, tag);
      end
   endtask

   task automatic test_ct_basic();
      check_one("ct_basic", 1'b0, 16'd3, 16'd5, 16'd4, 4'hA, 16'd6, 16'd0);
      check_one("ct_wrap_sub", 1'b0, 16'd0, 16'd1, 16'd1, 4'h3, 16'd1, 16'd16);
   endtask

   task automatic test_gs_basic();
      check_one("gs_basic", 1'b1, 16'd3, 16'd5, 16'd4, 4'h5, 16'd8, 16'd9);
   endtask

   task automatic test_wrap();
      check_one("ct_extreme", 1'b0, 16'd16, 16'd16, 16'd16, 4'h1, 16'd0, 16'd15);
      check_one("gs_extreme", 1'b1, 16'd16, 16'd16, 16'd16, 4'h2, 16'd15, 16'd0);
      check_one("ct_unreduced", 1'b0, 16'd20, 16'd0, 16'd5, 4'h7, 16'd3, 16'd3);
      check_one("gs_max_input", 1'b1, 16'd65534, 16'd0, 16'd1, 4'hF, 16'd16, 16'd16);
   endtask

   task automatic test_stream_stall();
      logic [15:0] pat;
      logic [15:0] exp_a[$], exp_b[$];
      logic [3:0]  exp_t[$];
      logic [31:0] r;
      logic [15:0] u, v, w, sa, sb, ea, eb;
      logic [3:0]  st, et;
      logic        stalled;
      int          sent, rcvd, cyc, extra;
      pat = 16'b1011_0010_1110_0101;
      sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; sa = '0; sb = '0; st = '0;
      while (rcvd < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_a !== sa || out_b !== sb || out_tag !== st) begin
               n_errors++;
               $display("FAIL stream_hold: v=%b a=%0d b=%0d tag=%0d expected 1 %0d %0d %0d",
                        out_valid, out_a, out_b, out_tag, sa, sb, st);
            end
         end
         out_ready = pat[cyc % 16];
         if (sent < 8) begin
            u = 16'(sent * 7 + 3); v = 16'(sent * 11 + 20); w = 16'(sent * 5 + 2);
            in_valid = 1'b1; in_mode = sent[0]; in_u = u; in_v = v; in_twiddle = w;
            in_tag = 4'(sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         n_checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            n_errors++;
            $display("FAIL stream_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_t.size() == 0) begin
               n_errors++;
               $display("FAIL stream_extra: unexpected output tag=%0d", out_tag);
            end else begin
               ea = exp_a.pop_front(); eb = exp_b.pop_front(); et = exp_t.pop_front();
               if (out_a !== ea || out_b !== eb || out_tag !== et) begin
                  n_errors++;
                  $display("FAIL stream_data: a=%0d b=%0d tag=%0d expected %0d %0d %0d",
                           out_a, out_b, out_tag, ea, eb, et);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            r = ref_ab(in_mode, int'(u), int'(v), int'(w));
            exp_a.push_back(r[31:16]); exp_b.push_back(r[15:0]); exp_t.push_back(in_tag);
            sent++;
         end
         stalled = out_valid && !out_ready;
         sa = out_a; sb = out_b; st = out_tag;
      end
      n_checks++;
      if (rcvd !== 8 || sent !== 8) begin
         n_errors++;
         $display("FAIL stream_count: sent=%0d received=%0d expected 8 8", sent, rcvd);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_errors++;
         $display("FAIL stream_dup: got %0d extra outputs expected 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      out_ready = 1'b1;
      for (int k = 0; k <= 13; k++) begin
         @(negedge clk);
         if (k >= 1) begin
            n_checks++;
            if (busy !== (k <= 12) || out_valid !== (k >= 3 && k <= 12) || in_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL b2b_flags cycle %0d: busy=%b out_valid=%b in_ready=%b expected %b %b 1",
                        k, busy, out_valid, in_ready, k <= 12, k >= 3 && k <= 12);
            end
            if (k >= 3 && k <= 12) begin
               r = ref_ab(1'b0, k - 3, 1, 1);
               n_checks++;
               if (out_tag !== 4'(k - 3) || out_a !== r[31:16] || out_b !== r[15:0]) begin
                  n_errors++;
                  $display("FAIL b2b_data cycle %0d: a=%0d b=%0d tag=%0d expected %0d %0d %0d",
                           k, out_a, out_b, out_tag, r[31:16], r[15:0], k - 3);
               end
            end
         end
         in_valid = (k < 10);
         in_mode = 1'b0; in_u = 16'(k); in_v = 16'd1; in_twiddle = 16'd1; in_tag = 4'(k);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int stray;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_mode = 1'(k); in_u = 16'(k + 1); in_v = 16'd2; in_twiddle = 16'd3;
         in_tag = 4'(k + 8);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_pre_stall: out_valid=%b busy=%b in_ready=%b expected 1 1 0",
                  out_valid, busy, in_ready);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_a !== 16'd0 || out_tag !== 4'd0) begin
         n_errors++;
         $display("FAIL rst_mid: out_valid=%b busy=%b a=%0d tag=%0d expected 0 0 0 0",
                  out_valid, busy, out_a, out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || busy) stray++;
      end
      n_checks++;
      if (stray !== 0) begin
         n_errors++;
         $display("FAIL rst_stale: got %0d cycles with stale activity expected 0", stray);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      in_valid = 1'b0; in_mode = 1'b0; in_u = '0; in_v = '0; in_twiddle = '0; in_tag = '0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_ct_basic();
      test_gs_basic();
      test_wrap();
      test_stream_stall();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
